// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the ProjectB processor.
// Drives the fetch handshake (PC_clr/PC_up/IR_ld), decodes the latched
// instruction and issues data-memory, register-file and ALU control.
// NOOP/STORE/ADD/SUB/HALT take 3 cycles (FETCH, DECODE, execute); LOAD takes 4.
// Optional feature macro: CU_ILLEGAL_TRAP_EN
//   defined   -> illegal opcodes (0110-1111) halt the machine
//   undefined -> illegal opcodes execute as NOOP
// Outputs come from registers loaded with the decode of the *next* state.
// IR_ld is only asserted in FETCH, so ir is already the new word by the edge
// that leaves DECODE and stays constant until the next FETCH. The registered
// decode therefore shows the same values as a combinational decode of the
// current state and ir.
module control_unit #(
   parameter int         IW       = 16,
   parameter int         DA_W     = 8,
   parameter int         RA_W     = 4,
   parameter logic [2:0] ALU_PASS = 3'b000,
   parameter logic [2:0] ALU_ADD  = 3'b001,
   parameter logic [2:0] ALU_SUB  = 3'b010
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [IW-1:0]   ir,
   output logic            PC_clr,
   output logic            PC_up,
   output logic            IR_ld,
   output logic [DA_W-1:0] D_addr,
   output logic            D_wr,
   output logic            RF_s,
   output logic [RA_W-1:0] RF_W_addr,
   output logic            RF_W_en,
   output logic [RA_W-1:0] RF_Ra_addr,
   output logic [RA_W-1:0] RF_Rb_addr,
   output logic [2:0]      ALU_s0,
   output logic            halted,
   output logic [3:0]      state_o
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        w_opcode;

   // Instruction fields
   logic [DA_W-1:0]   w_load_addr;
   logic [DA_W-1:0]   w_store_addr;
   logic [RA_W-1:0]   w_ra;
   logic [RA_W-1:0]   w_rb;
   logic [RA_W-1:0]   w_rd;

   // Registered outputs
   logic              r_pc_clr;
   logic              r_pc_up;
   logic              r_ir_ld;
   logic [DA_W-1:0]   r_d_addr;
   logic              r_d_wr;
   logic              r_rf_s;
   logic [RA_W-1:0]   r_rf_w_addr;
   logic              r_rf_w_en;
   logic [RA_W-1:0]   r_rf_ra_addr;
   logic [RA_W-1:0]   r_rf_rb_addr;
   logic [2:0]        r_alu_s0;
   logic              r_halted;

   assign w_opcode     = ir[IW-1 -: 4];
   assign w_load_addr  = ir[IW-5 -: DA_W];
   assign w_store_addr = ir[DA_W-1:0];
   assign w_ra         = ir[IW-5 -: RA_W];
   assign w_rb         = ir[IW-9 -: RA_W];
   assign w_rd         = ir[RA_W-1:0];

   // Next-state selection; DECODE dispatches on the opcode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:   w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               4'b0000: w_next = S_NOOP;
               4'b0001: w_next = S_STORE;
               4'b0010: w_next = S_LOAD_A;
               4'b0011: w_next = S_ADD;
               4'b0100: w_next = S_SUB;
               4'b0101: w_next = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
               default: w_next = S_HALT;
`else
               default: w_next = S_NOOP;
`endif
            endcase
         end
         S_LOAD_A: w_next = S_LOAD_B;
         S_LOAD_B: w_next = S_FETCH;
         S_NOOP:   w_next = S_FETCH;
         S_STORE:  w_next = S_FETCH;
         S_ADD:    w_next = S_FETCH;
         S_SUB:    w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_INIT;
      endcase
   end

   // State register plus output registers loaded with the decode of the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_INIT;
         r_pc_clr     <= 1'b1;
         r_pc_up      <= 1'b0;
         r_ir_ld      <= 1'b0;
         r_d_addr     <= '0;
         r_d_wr       <= 1'b0;
         r_rf_s       <= 1'b0;
         r_rf_w_addr  <= '0;
         r_rf_w_en    <= 1'b0;
         r_rf_ra_addr <= '0;
         r_rf_rb_addr <= '0;
         r_alu_s0     <= ALU_PASS;
         r_halted     <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_pc_clr     <= 1'b0;
         r_pc_up      <= 1'b0;
         r_ir_ld      <= 1'b0;
         r_d_addr     <= '0;
         r_d_wr       <= 1'b0;
         r_rf_s       <= 1'b0;
         r_rf_w_addr  <= '0;
         r_rf_w_en    <= 1'b0;
         r_rf_ra_addr <= '0;
         r_rf_rb_addr <= '0;
         r_alu_s0     <= ALU_PASS;
         r_halted     <= 1'b0;
         case (w_next)
            S_INIT: r_pc_clr <= 1'b1;
            S_FETCH: begin
               r_ir_ld <= 1'b1;
               r_pc_up <= 1'b1;
            end
            S_LOAD_A: begin
               r_d_addr <= w_load_addr;
               r_rf_s   <= 1'b1;
            end
            S_LOAD_B: begin
               r_d_addr    <= w_load_addr;
               r_rf_s      <= 1'b1;
               r_rf_w_addr <= w_rd;
               r_rf_w_en   <= 1'b1;
            end
            S_STORE: begin
               r_d_addr     <= w_store_addr;
               r_rf_ra_addr <= w_ra;
               r_d_wr       <= 1'b1;
            end
            S_ADD: begin
               r_rf_ra_addr <= w_ra;
               r_rf_rb_addr <= w_rb;
               r_rf_w_addr  <= w_rd;
               r_rf_w_en    <= 1'b1;
               r_alu_s0     <= ALU_ADD;
            end
            S_SUB: begin
               r_rf_ra_addr <= w_ra;
               r_rf_rb_addr <= w_rb;
               r_rf_w_addr  <= w_rd;
               r_rf_w_en    <= 1'b1;
               r_alu_s0     <= ALU_SUB;
            end
            S_HALT: r_halted <= 1'b1;
            default: ;
         endcase
      end
   end

   assign PC_clr     = r_pc_clr;
   assign PC_up      = r_pc_up;
   assign IR_ld      = r_ir_ld;
   assign D_addr     = r_d_addr;
   assign D_wr       = r_d_wr;
   assign RF_s       = r_rf_s;
   assign RF_W_addr  = r_rf_w_addr;
   assign RF_W_en    = r_rf_w_en;
   assign RF_Ra_addr = r_rf_ra_addr;
   assign RF_Rb_addr = r_rf_rb_addr;
   assign ALU_s0     = r_alu_s0;
   assign halted     = r_halted;
   assign state_o    = r_state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed test of the control_unit sequencer.
// Each step advances one clock, then compares every DUT output, packed into
// one vector, against a hand-written expectation.
// Honours CU_ILLEGAL_TRAP_EN the same way as the design.
module tb_control_unit;

   logic        clk;
   logic        reset;
   logic [15:0] ir;
   logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, halted;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state_o;
   logic [2:0]  ALU_s0;

   int n_checks = 0;
   int n_fail   = 0;

   control_unit dut (
      .clk        (clk),
      .reset      (reset),
      .ir         (ir),
      .PC_clr     (PC_clr),
      .PC_up      (PC_up),
      .IR_ld      (IR_ld),
      .D_addr     (D_addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_addr  (RF_W_addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .ALU_s0     (ALU_s0),
      .halted     (halted),
      .state_o    (state_o)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare all outputs against expectations.
   // Packed order: state, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
   //               W_addr, W_en, Ra, Rb, ALU_s0, halted
   task automatic check(input string tag, input logic [3:0] st,
                        input logic pc_clr, input logic pc_up, input logic ir_ld,
                        input logic [7:0] d_addr, input logic d_wr, input logic rf_s,
                        input logic [3:0] w_addr, input logic w_en,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [2:0] alu, input logic hlt);
      logic [33:0] obs, exp;
      obs = {state_o, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
             RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, halted};
      exp = {st, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s,
             w_addr, w_en, ra, rb, alu, hlt};
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Shorthands for common states
   task automatic check_fetch(input string tag);
      check(tag, 4'd1, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
   endtask

   task automatic check_idle(input string tag, input logic [3:0] st, input logic hlt);
      check(tag, st, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, hlt);
   endtask

   initial begin
      reset = 1'b1;
      ir    = 16'h0000;

      // reset held two cycles
      step();
      step();
      check("reset_init", 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
      reset = 1'b0;

      // INIT -> FETCH -> DECODE, LOAD [0xA5] -> R3
      step();
      check_fetch("fetch_after_init");
      ir = 16'h2A53;
      step();
      check_idle("decode_load", 4'd2, 0);
      step();
      check("load_a", 4'd4, 0, 0, 0, 8'hA5, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
      step();
      check("load_b", 4'd5, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'b000, 0);
      step();
      check_fetch("fetch_after_load");

      // STORE R12 -> [0x42], single write cycle
      ir = 16'h1C42;
      step();
      check_idle("decode_store", 4'd2, 0);
      step();
      check("store", 4'd6, 0, 0, 0, 8'h42, 1, 0, 4'h0, 0, 4'hC, 4'h0, 3'b000, 0);
      step();
      check_fetch("fetch_after_store");

      // ADD R1+R2 -> R7
      ir = 16'h3127;
      step();
      check_idle("decode_add", 4'd2, 0);
      step();
      check("add", 4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h7, 1, 4'h1, 4'h2, 3'b001, 0);
      step();
      check_fetch("fetch_after_add");

      // SUB R1-R2 -> R7
      ir = 16'h4127;
      step();
      check_idle("decode_sub", 4'd2, 0);
      step();
      check("sub", 4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h7, 1, 4'h1, 4'h2, 3'b010, 0);
      step();
      check_fetch("fetch_after_sub");

      // NOOP
      ir = 16'h0000;
      step();
      check_idle("decode_noop", 4'd2, 0);
      step();
      check_idle("noop", 4'd3, 0);
      step();
      check_fetch("fetch_after_noop");

      // Illegal opcode 0xF
      ir = 16'hF000;
      step();
      check_idle("decode_illegal", 4'd2, 0);
      step();
`ifdef CU_ILLEGAL_TRAP_EN
      check_idle("illegal_trap_halt", 4'd9, 1);
      step();
      check_idle("illegal_trap_stays", 4'd9, 1);
      reset = 1'b1;
      step();
      check("reset_from_trap", 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
      reset = 1'b0;
      step();
      check_fetch("fetch_after_trap_reset");
`else
      check_idle("illegal_as_noop", 4'd3, 0);
      step();
      check_fetch("fetch_after_illegal");
`endif

      // Mid-instruction reset during LOAD_B: no register write follows
      ir = 16'h2A53;
      step();
      check_idle("decode_load2", 4'd2, 0);
      step();
      check("load_a2", 4'd4, 0, 0, 0, 8'hA5, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
      step();
      check("load_b2", 4'd5, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'b000, 0);
      reset = 1'b1;
      step();
      check("reset_mid_load", 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
      reset = 1'b0;
      step();
      check_fetch("fetch_after_mid_reset");

      // HALT holds for 20 cycles, then reset recovers
      ir = 16'h5000;
      step();
      check_idle("decode_halt", 4'd2, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         check_idle($sformatf("halt_cycle_%0d", i), 4'd9, 1);
      end
      reset = 1'b1;
      step();
      check("reset_from_halt", 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0);
      reset = 1'b0;
      step();
      check_fetch("fetch_after_halt_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
